dc_data_req: RTL

- Issue side of the data-memory path.
- Takes one decoded load/store per cycle from the DC stage, builds the byte strobes and the lane-aligned write data, and drives an SRAM-like request/response bus (req/addr_ok/data_ok).
- Returns the raw 32-bit read word, registered, to the MEM stage. The MEM stage does all load-side extraction.
- Holds the pipeline via stall_req while a transaction is outstanding, and safely drops responses that belong to flushed instructions.

---
 rtl/dc_data_req_pkg.sv | 38 +++
 rtl/dc_data_req_if.sv | 24 ++
 rtl/dc_data_req_store_align.sv | 92 +++++++++
 rtl/dc_data_req.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dc_data_req_pkg.sv
// Shared types and constants for the data-memory issue path.
// Op-vector bit positions follow the DC_TO_MEM bus field order.
package dc_data_req_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int unsigned LOAD_W  = 5;
    localparam int unsigned STORE_W = 3;
    localparam int unsigned EXTRA_W = 4;

    // op_load = {lb,lbu,lh,lhu,lw}
    localparam int unsigned LD_LB  = 4;
    localparam int unsigned LD_LBU = 3;
    localparam int unsigned LD_LH  = 2;
    localparam int unsigned LD_LHU = 1;
    localparam int unsigned LD_LW  = 0;

    // op_store = {sb,sh,sw}
    localparam int unsigned ST_SB = 2;
    localparam int unsigned ST_SH = 1;
    localparam int unsigned ST_SW = 0;

    // op_extra = {lwl,lwr,swl,swr}
    localparam int unsigned EX_LWL = 3;
    localparam int unsigned EX_LWR = 2;
    localparam int unsigned EX_SWL = 1;
    localparam int unsigned EX_SWR = 0;

endpackage

// File: rtl/dc_data_req_if.sv
// SRAM-like data bus between the issue logic (master) and memory (slave).
interface dc_data_req_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dc_data_req_store_align.sv
// Combinational decode of a memory op into bus size, strobes, lane data and alignment.
// swl/swr/lwl/lwr are decoded only when UNALIGNED_LWLR_EN is defined.
module dc_store_align
    import dc_data_req_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [LOAD_W-1:0]  op_load,
    input  logic [STORE_W-1:0] op_store,
    input  logic [EXTRA_W-1:0] op_extra,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        rt,
    output logic               valid,
    output logic               wr,
    output logic [1:0]         size,
    output logic [3:0]         wstrb,
    output logic [31:0]        wdata,
    output logic [ADDR_W-1:0]  aligned_addr,
    output logic               misaligned
);
    logic [1:0] a;
    assign a = addr[1:0];

`ifndef UNALIGNED_LWLR_EN
    logic unused_extra;
    assign unused_extra = ^op_extra;
`endif

    always_comb begin
        valid        = 1'b0;
        wr           = 1'b0;
        size         = SIZE_BYTE;
        wstrb        = '0;
        wdata        = '0;
        aligned_addr = addr;
        misaligned   = 1'b0;
        if (|op_load) begin
            valid = 1'b1;
            if (op_load[LD_LB] || op_load[LD_LBU]) begin
                size = SIZE_BYTE;
            end else if (op_load[LD_LH] || op_load[LD_LHU]) begin
                size       = SIZE_HALF;
                misaligned = a[0];
            end else begin
                size       = SIZE_WORD;
                misaligned = |a;
            end
        end else if (|op_store) begin
            valid = 1'b1;
            wr    = 1'b1;
            if (op_store[ST_SB]) begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << a;
                wdata = {4{rt[7:0]}};
            end else if (op_store[ST_SH]) begin
                size       = SIZE_HALF;
                wstrb      = a[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{rt[15:0]}};
                misaligned = a[0];
            end else begin
                size       = SIZE_WORD;
                wstrb      = 4'b1111;
                wdata      = rt;
                misaligned = |a;
            end
        end
`ifdef UNALIGNED_LWLR_EN
        else if (|op_extra) begin
            valid        = 1'b1;
            size         = SIZE_WORD;
            aligned_addr = {addr[ADDR_W-1:2], 2'b00};
            if (op_extra[EX_SWL]) begin
                wr = 1'b1;
                case (a)
                    2'd0:    begin wstrb = 4'b0001; wdata = {24'b0, rt[31:24]}; end
                    2'd1:    begin wstrb = 4'b0011; wdata = {16'b0, rt[31:16]}; end
                    2'd2:    begin wstrb = 4'b0111; wdata = {8'b0, rt[31:8]};   end
                    default: begin wstrb = 4'b1111; wdata = rt;                 end
                endcase
            end else if (op_extra[EX_SWR]) begin
                wr = 1'b1;
                case (a)
                    2'd0:    begin wstrb = 4'b1111; wdata = rt;                 end
                    2'd1:    begin wstrb = 4'b1110; wdata = {rt[23:0], 8'b0};   end
                    2'd2:    begin wstrb = 4'b1100; wdata = {rt[15:0], 16'b0};  end
                    default: begin wstrb = 4'b1000; wdata = {rt[7:0], 24'b0};   end
                endcase
            end
        end
`endif
    end
endmodule

// File: rtl/dc_data_req.sv
// Data-memory request issue: one load/store per cycle onto the SRAM-like bus.
// Optional unaligned swl/swr/lwl/lwr support via UNALIGNED_LWLR_EN.
module dc_data_req
    import dc_data_req_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               op_valid,
    input  logic [LOAD_W-1:0]  op_load,
    input  logic [STORE_W-1:0] op_store,
    input  logic [EXTRA_W-1:0] op_extra,
    input  logic [ADDR_W-1:0]  op_addr,
    input  logic [31:0]        op_rt,
    output logic               stall_req,
    output logic               ale,
    dc_data_req_if.master      bus,
    output logic [31:0]        data_sram_rdata,
    output logic               rdata_valid
);
    state_e state_q, state_d;

    logic              sa_valid, sa_wr, sa_misaligned;
    logic [1:0]        sa_size;
    logic [3:0]        sa_wstrb;
    logic [31:0]       sa_wdata;
    logic [ADDR_W-1:0] sa_addr;

    logic              req_wr;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_wdata;

    logic align_fault, idle_op, accept, stall, capture;

    dc_store_align #(.ADDR_W(ADDR_W)) u_align (
        .op_load      (op_load),
        .op_store     (op_store),
        .op_extra     (op_extra),
        .addr         (op_addr),
        .rt           (op_rt),
        .valid        (sa_valid),
        .wr           (sa_wr),
        .size         (sa_size),
        .wstrb        (sa_wstrb),
        .wdata        (sa_wdata),
        .aligned_addr (sa_addr),
        .misaligned   (sa_misaligned)
    );

    assign align_fault = CHECK_ALIGN && sa_misaligned;
    assign idle_op     = (state_q == S_IDLE) && op_valid && !flush && sa_valid;
    assign accept      = idle_op && !align_fault;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ADDR;
                    stall   = 1'b1;
                end
            end
            S_ADDR: begin
                if (flush) begin
                    // accepted-but-flushed requests still owe a response unless it arrives now
                    if (bus.data_addr_ok && !bus.data_data_ok) begin
                        state_d = S_DROP;
                        stall   = op_valid;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        state_d = S_IDLE;
                        capture = !req_wr;
                    end else begin
                        state_d = S_DATA;
                        stall   = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.data_data_ok) begin
                    state_d = S_IDLE;
                    capture = !req_wr && !flush;
                end else if (flush) begin
                    state_d = S_DROP;
                    stall   = op_valid;
                end else begin
                    stall = 1'b1;
                end
            end
            S_DROP: begin
                stall = op_valid;
                if (bus.data_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            req_wr          <= 1'b0;
            req_size        <= SIZE_BYTE;
            req_addr        <= '0;
            req_wstrb       <= '0;
            req_wdata       <= '0;
            data_sram_rdata <= '0;
            rdata_valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_valid <= capture;
            if (capture) data_sram_rdata <= bus.data_rdata;
            if (accept) begin
                req_wr    <= sa_wr;
                req_size  <= sa_size;
                req_addr  <= sa_addr;
                req_wstrb <= sa_wstrb;
                req_wdata <= sa_wdata;
            end
        end
    end

    // Combinational outputs are gated by rst so an asserted reset silences them at once
    assign stall_req = stall && rst;
    assign ale       = idle_op && align_fault && rst;

    assign bus.data_req   = (state_q == S_ADDR);
    assign bus.data_wr    = req_wr;
    assign bus.data_size  = req_size;
    assign bus.data_addr  = req_addr;
    assign bus.data_wstrb = req_wstrb;
    assign bus.data_wdata = req_wdata;
endmodule
